// File: rtl/i2c_txn_arbiter_if.sv
// i2c_txn_arbiter_if: bundle of the requester-side and controller-side
// signals of the I2C transaction arbiter.
//   requester side : req, req_addr, req_wdata, req_rw -> gnt, done, err, rdata, busy
//   controller side: m_enable, m_addr, m_data_in, m_rw -> m_ready, m_data_out
// modport slave  : the arbiter's view.
// modport master : the view of the environment (requesters + controller).
interface i2c_txn_arbiter_if #(parameter int NREQ = 4);
  logic [NREQ-1:0]   req;
  logic [7*NREQ-1:0] req_addr;
  logic [8*NREQ-1:0] req_wdata;
  logic [NREQ-1:0]   req_rw;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic [NREQ-1:0]   err;
  logic [7:0]        rdata;
  logic              busy;
  logic              m_enable;
  logic [6:0]        m_addr;
  logic [7:0]        m_data_in;
  logic              m_rw;
  logic              m_ready;
  logic [7:0]        m_data_out;

  modport slave (
    input  req, req_addr, req_wdata, req_rw, m_ready, m_data_out,
    output gnt, done, err, rdata, busy, m_enable, m_addr, m_data_in, m_rw
  );
  modport master (
    output req, req_addr, req_wdata, req_rw, m_ready, m_data_out,
    input  gnt, done, err, rdata, busy, m_enable, m_addr, m_data_in, m_rw
  );
endinterface

// File: rtl/i2c_txn_arbiter.sv
// i2c_txn_arbiter: round-robin arbiter sharing one I2C controller between
// NREQ requesters. One single-byte read/write per grant, an EN_CYCLES wide
// enable pulse to the controller, completion tracked on m_ready, and a
// TIMEOUT cycle abort that reports err together with done.
// Ports:
//   i_clk : clock, rising edge
//   i_rst : asynchronous reset, active low
//   bus   : i2c_txn_arbiter_if.slave (requester and controller signals)
module i2c_txn_arbiter #(
  parameter int NREQ      = 4,
  parameter int EN_CYCLES = 5,
  parameter int TIMEOUT   = 1023
) (
  input  logic                i_clk,
  input  logic                i_rst,
  i2c_txn_arbiter_if.slave    bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int EW = $clog2(EN_CYCLES + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WBUSY = 3'd2;
  localparam logic [2:0] S_WDONE = 3'd3;
  localparam logic [2:0] S_CMPL  = 3'd4;

  localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [EW-1:0] E_LAST = EW'(EN_CYCLES - 1);

  logic [2:0]      r_state;
  logic [IW-1:0]   r_last, r_g;
  logic [NREQ-1:0] r_gnt;
  logic            r_done, r_err, r_en, r_rw, r_seen;
  logic [7:0]      r_rdata, r_wdata;
  logic [6:0]      r_addr;
  logic [TW-1:0]   r_tcnt;
  logic [EW-1:0]   r_ecnt;

  logic            w_found, w_tmo;
  logic [IW-1:0]   w_win;
  logic [NREQ-1:0] w_oh;

  // (base + k) mod NREQ for 1 <= k <= NREQ
  function automatic logic [IW-1:0] f_idx(input logic [IW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NREQ) s = s - NREQ;
    return IW'(s);
  endfunction

  // Round-robin search starting one past the last served requester.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_oh    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!w_found && bus.req[f_idx(r_last, k)]) begin
        w_found = 1'b1;
        w_win   = f_idx(r_last, k);
      end
    end
    w_oh[w_win] = 1'b1;
  end

  // Counter reaches TIMEOUT on this edge.
  assign w_tmo = (r_tcnt >= T_LAST);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
      r_last  <= IW'(NREQ - 1);
      r_g     <= '0;
      r_gnt   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_en    <= 1'b0;
      r_rw    <= 1'b0;
      r_seen  <= 1'b0;
      r_rdata <= '0;
      r_wdata <= '0;
      r_addr  <= '0;
      r_tcnt  <= '0;
      r_ecnt  <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (r_state != S_IDLE && r_tcnt != T_MAX) r_tcnt <= r_tcnt + 1'b1;
      case (r_state)
        S_IDLE: begin
          if (bus.m_ready && w_found) begin
            r_g     <= w_win;
            r_gnt   <= w_oh;
            r_addr  <= bus.req_addr[int'(w_win)*7 +: 7];
            r_wdata <= bus.req_wdata[int'(w_win)*8 +: 8];
            r_rw    <= bus.req_rw[w_win];
            r_tcnt  <= '0;
            r_ecnt  <= '0;
            r_seen  <= 1'b0;
            r_en    <= 1'b1;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE, S_WBUSY, S_WDONE: begin
          if (w_tmo) begin
            r_en    <= 1'b0;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
            r_state <= S_CMPL;
          end else if (r_state == S_ISSUE) begin
            // controller may already have gone busy while enable is held
            if (!bus.m_ready) r_seen <= 1'b1;
            if (r_ecnt == E_LAST) begin
              r_en    <= 1'b0;
              r_state <= S_WBUSY;
            end else begin
              r_ecnt <= r_ecnt + 1'b1;
            end
          end else if (r_state == S_WBUSY) begin
            if (r_seen || !bus.m_ready) r_state <= S_WDONE;
          end else if (bus.m_ready) begin
            // done/rdata are registered here so they are visible during COMPLETE
            r_done  <= 1'b1;
            if (r_rw) r_rdata <= bus.m_data_out;
            r_state <= S_CMPL;
          end
        end
        S_CMPL: begin
          r_last  <= r_g;
          r_gnt   <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.done      = r_done ? r_gnt : '0;
  assign bus.err       = r_err  ? r_gnt : '0;
  assign bus.rdata     = r_rdata;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.m_enable  = r_en;
  assign bus.m_addr    = r_addr;
  assign bus.m_data_in = r_wdata;
  assign bus.m_rw      = r_rw;
endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Testbench for i2c_txn_arbiter: directed scenarios with randomized fields
// and controller timing, checked against a requester/arbitration model.
module tb_i2c_txn_arbiter;
  localparam int N   = 4;
  localparam int ENC = 5;
  localparam int TMO = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  i2c_txn_arbiter_if #(.NREQ(N)) bus();
  i2c_txn_arbiter #(.NREQ(N), .EN_CYCLES(ENC), .TIMEOUT(TMO)) dut (
    .i_clk(clk), .i_rst(rst_n), .bus(bus));

  int n_pass = 0;
  int n_tot  = 0;

  // model: pending requests, their fields, last served, last read byte
  bit         pend [N];
  logic [6:0] fa   [N];
  logic [7:0] fw   [N];
  bit         frw  [N];
  int         mlast;
  logic [7:0] mrd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  function automatic int winner();
    for (int k = 1; k <= N; k++)
      if (pend[(mlast + k) % N]) return (mlast + k) % N;
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [6:0] a, input logic [7:0] w, input bit rw);
    pend[i] = 1; fa[i] = a; fw[i] = w; frw[i] = rw;
    bus.req[i] = 1'b1;
    bus.req_addr[7*i +: 7]  = a;
    bus.req_wdata[8*i +: 8] = w;
    bus.req_rw[i] = rw;
  endtask

  task automatic set_rand(input int i);
    set_req(i, 7'($urandom), 8'($urandom), 1'($urandom));
  endtask

  task automatic drop_req(input int i);
    pend[i] = 0;
    bus.req[i] = 1'b0;
  endtask

  task automatic model_reset();
    mlast = N - 1;
    mrd = 8'h00;
  endtask

  // One transaction from grant to the cycle after done. The controller side
  // drops m_ready at d1 and raises it at cr (cycles counted from grant).
  task automatic do_txn(input bit tmo, input bit keep, input int rdv, output int g);
    int w, c, d1, L, cr, enc, exp_c;
    bit held;
    logic [7:0] rb;
    logic [N-1:0] m;
    w = winner();
    m = '0;
    if (w >= 0) m[w] = 1'b1;
    for (int t = 0; t < 100 && bus.gnt == '0; t++) @(negedge clk);
    g = -1;
    for (int i = 0; i < N; i++) if (bus.gnt[i]) g = i;
    chk("gnt", 32'(bus.gnt), 32'(m));
    if (w >= 0)
      chk("fields", 32'({bus.m_enable, bus.m_rw, bus.m_addr, bus.m_data_in}),
          32'({1'b1, frw[w], fa[w], fw[w]}));
    d1 = $urandom_range(1, 7);
    L  = $urandom_range((d1 < 5) ? 6 - d1 : 1, 6);
    cr = d1 + L;
    rb = (rdv < 0) ? 8'($urandom) : 8'(rdv);
    enc = 0; held = 1; c = 0;
    while (bus.done == '0 && c < 40) begin
      enc += int'(bus.m_enable);
      if (bus.gnt !== m) held = 0;
      if (!tmo) begin
        if (c == d1) bus.m_ready = 1'b0;
        if (c == cr) begin bus.m_ready = 1'b1; bus.m_data_out = rb; end
      end
      @(negedge clk);
      c++;
    end
    exp_c = tmo ? TMO : cr + 1;
    if (w >= 0) begin
      mlast = w;
      if (!tmo && frw[w]) mrd = rb;
    end
    chk("done",   32'(bus.done), 32'(m));
    chk("err",    32'(bus.err), tmo ? 32'(m) : 32'd0);
    chk("lat",    32'(c), 32'(exp_c));
    chk("en_len", 32'(enc), 32'(ENC));
    chk("rdata",  32'(bus.rdata), 32'(mrd));
    chk("held",   32'(held), 32'd1);
    if (w >= 0) begin
      if (keep) set_rand(w);
      else drop_req(w);
    end
    @(negedge clk);
    chk("post", 32'({bus.done, bus.err, bus.gnt, bus.busy}), 32'd0);
    chk("rdata_hold", 32'(bus.rdata), 32'(mrd));
  endtask

  initial begin
    int g;
    int ord [5];
    bus.req = '0; bus.req_addr = '0; bus.req_wdata = '0; bus.req_rw = '0;
    bus.m_ready = 1'b1; bus.m_data_out = 8'h00;
    for (int i = 0; i < N; i++) begin pend[i] = 0; fa[i] = 0; fw[i] = 0; frw[i] = 0; end
    model_reset();

    // reset state
    #1;
    chk("rst_ctrl", 32'({bus.gnt, bus.done, bus.err, bus.m_enable, bus.busy, bus.m_rw}), 32'd0);
    chk("rst_data", 32'({bus.rdata, bus.m_addr, bus.m_data_in}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // single write
    set_req(0, 7'b1010110, 8'hAA, 1'b0);
    do_txn(1'b0, 1'b0, -1, g);

    // single read returning 0x3C
    set_req(2, 7'($urandom), 8'($urandom), 1'b1);
    do_txn(1'b0, 1'b0, 8'h3C, g);
    chk("read_3c", 32'(bus.rdata), 32'h3C);

    // timeout: m_ready stays high, rdata must keep 0x3C
    set_rand(1);
    do_txn(1'b1, 1'b0, -1, g);
    chk("tmo_rdata", 32'(bus.rdata), 32'h3C);

    // busy bus: no grant while m_ready low
    bus.m_ready = 1'b0;
    set_rand(0);
    repeat (6) @(negedge clk);
    chk("busy_nogrant", 32'({bus.gnt, bus.busy}), 32'd0);
    bus.m_ready = 1'b1;
    @(negedge clk);
    chk("gnt_1edge", 32'(bus.gnt), 32'd1);
    do_txn(1'b0, 1'b0, -1, g);

    // contention from reset
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < N; i++) set_rand(i);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) do_txn(1'b0, k < 4, -1, ord[k]);
    for (int i = 1; i < N; i++) drop_req(i);
    chk("order", 32'({ord[0][2:0], ord[1][2:0], ord[2][2:0], ord[3][2:0], ord[4][2:0]}),
        32'(15'b000_001_010_011_000));
    @(negedge clk);

    // random mix of overlapping requesters
    for (int t = 0; t < 10; t++) begin
      if (winner() < 0) set_rand($urandom_range(0, N-1));
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(0, 1) == 1) set_rand(i);
      do_txn(1'b0, 1'($urandom), -1, g);
    end
    for (int i = 0; i < N; i++) drop_req(i);
    @(negedge clk);
    @(negedge clk);
    // a kept request might have been granted just before the drop
    if (bus.gnt != '0) begin
      for (int t = 0; t < 40 && bus.done == '0; t++) @(negedge clk);
      @(negedge clk);
    end
    if (bus.busy) begin
      for (int t = 0; t < 40 && bus.busy; t++) @(negedge clk);
    end

    // reset in WAIT_DONE
    set_rand(3);
    for (int t = 0; t < 100 && bus.gnt == '0; t++) @(negedge clk);
    chk("rst_gnt3", 32'(bus.gnt), 32'h8);
    for (int c = 0; c < 10; c++) begin
      if (c == 1) bus.m_ready = 1'b0;
      if (c == 3) set_rand(0);
      @(negedge clk);
    end
    chk("busy_wd", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ctrl", 32'({bus.gnt, bus.done, bus.err, bus.m_enable, bus.busy, bus.m_rw}), 32'd0);
    chk("mid_rst_data", 32'({bus.rdata, bus.m_addr, bus.m_data_in}), 32'd0);
    model_reset();
    bus.m_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_nodone", 32'(bus.done), 32'd0);
    rst_n = 1'b1;
    do_txn(1'b0, 1'b0, -1, ord[0]);
    do_txn(1'b0, 1'b0, -1, ord[1]);
    chk("rst_order", 32'({ord[0][2:0], ord[1][2:0]}), 32'(6'b000_011));

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
